bbframe_data_field_reader: RTL and testbench
============================================

BBFRAME_DATA_FIELD_READER -- requirements
Module: bbframe_data_field_reader

Interface
REQ-001 SHALL have parameter STALL_LIMIT, default 64, meaning the EMPTY-cycle count that triggers padding (only with PAD_ON_UNDERFLOW_EN).
REQ-002 SHALL have port DCLK_IN  input  1  clock; all logic on rising edge.
REQ-003 SHALL have port RST  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port DATA_IN  input  8  prepared-TS FIFO q; valid one cycle after an accepted read.
REQ-005 SHALL have port BYTE_INDEX_A  input  8  UP byte index (1..UPL) of the byte on DATA_IN.
REQ-006 SHALL have port EMPTY  input  1  prepared-TS FIFO empty.
REQ-007 SHALL have port START  input  1  single-cycle request to assemble one data field.
REQ-008 SHALL have port DFL_BYTES  input  16  data field length in bytes, sampled on accepted START.
REQ-009 SHALL have port RD_REQ  output  1  FIFO read request.
REQ-010 SHALL have ports DATA_OUT  output  8 and DVALID_OUT  output  1, carrying the data field byte stream.
REQ-011 SHALL have ports SYNCD  output  16  (bit distance from field start to first UP start) and SYNCD_VALID  output  1.
REQ-012 SHALL have ports BUSY  output  1 and FRAME_DONE  output  1  (single-cycle pulse).

Function
REQ-013 SHALL implement states IDLE, READ, DRAIN, DONE.
REQ-014 In IDLE, START SHALL be accepted: latch DFL_BYTES, clear the byte counter, set SYNCD to 16'hFFFF, go to READ; with DFL_BYTES=0 go directly to DONE.
REQ-015 START while BUSY=1 SHALL be ignored.
REQ-016 In READ, RD_REQ SHALL be combinational: !EMPTY while requested count < latched DFL.
REQ-017 Each accepted read (RD_REQ & !EMPTY) SHALL increment the requested count; when it reaches DFL, go to DRAIN.
REQ-018 One cycle after each accepted read, DVALID_OUT=1, DATA_OUT=DATA_IN (DATA_OUT registered? no: passthrough of FIFO q), and the delivered count increments.
REQ-019 On the first delivered byte with BYTE_INDEX_A=1, SYNCD SHALL be set to delivered count (before increment) x 8; later UP starts SHALL not change it.
REQ-020 DRAIN SHALL last until the last byte is delivered (1 cycle), then DONE.
REQ-021 DONE SHALL assert FRAME_DONE and SYNCD_VALID for one cycle, then return to IDLE.
REQ-022 SYNCD SHALL hold its value until the next accepted START; 16'hFFFF means no UP start in field.
REQ-023 BUSY SHALL be 1 in all states except IDLE.
REQ-024 Count arithmetic SHALL be 16-bit unsigned; SYNCD x8 truncates to 16 bits (DFL_BYTES <= 8191 required by system).

Reset
REQ-025 RST low SHALL force IDLE, RD_REQ=0, DVALID_OUT=0, DATA_OUT=0, SYNCD=16'hFFFF, SYNCD_VALID=0, BUSY=0, FRAME_DONE=0, counters 0, mid-field included; no FRAME_DONE follows.

Configuration
REQ-026 With PAD_ON_UNDERFLOW_EN defined: in READ, STALL_LIMIT consecutive EMPTY cycles SHALL switch to PAD, emitting 0x00 bytes (DVALID_OUT=1, RD_REQ=0) one per cycle until DFL delivered, then DONE; stall counter clears on any accepted read.
REQ-027 Without PAD_ON_UNDERFLOW_EN: READ SHALL wait on EMPTY indefinitely; PAD state and stall counter absent.

Structure
REQ-028 Shared package SHALL hold the state enum, SYNCD_NONE = 16'hFFFF, and the DFL width constant.
REQ-029 Block SHALL be a single module; no sub-module.

Verification
REQ-030 FIFO preloaded starting at index 1, START with DFL=376 -> 376 bytes, SYNCD=0, FRAME_DONE after the last byte.
REQ-031 FIFO first byte at index 100 (NM, UPL 188), DFL=200 -> SYNCD=89x8=712.
REQ-032 DFL=50, all indices 2..51 -> SYNCD=16'hFFFF with SYNCD_VALID pulse.
REQ-033 DFL=0 -> no RD_REQ, FRAME_DONE 2 cycles after START.
REQ-034 PAD_ON_UNDERFLOW_EN, STALL_LIMIT=64: 10 bytes then EMPTY held, DFL=20 -> after 64 empty cycles, ten 0x00 bytes, FRAME_DONE.
REQ-035 RST low at byte 30 of DFL=100 -> all outputs at reset values, no FRAME_DONE; next START works normally.

Source files
------------

// File: rtl/bbframe_data_field_reader_pkg.sv
// Shared types and constants for the BBFRAME data field reader.
// Optional build macro: PAD_ON_UNDERFLOW_EN adds the PAD state.
package bbframe_data_field_reader_pkg;

   localparam int          DFL_W      = 16;
   localparam logic [15:0] SYNCD_NONE = 16'hFFFF;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_DRAIN = 3'd2,
`ifdef PAD_ON_UNDERFLOW_EN
      ST_DONE  = 3'd3,
      ST_PAD   = 3'd4
`else
      ST_DONE  = 3'd3
`endif
   } state_t;

   // Bit distance of a byte position; x8 wraps at 16 bits by design.
   function automatic logic [DFL_W-1:0] syncd_bits(input logic [DFL_W-1:0] byte_cnt);
      return byte_cnt << 3;
   endfunction

endpackage

// File: rtl/bbframe_data_field_reader.sv
// Pulls DFL_BYTES bytes from the prepared-TS FIFO, reports SYNCD of the first UP start.
// Build macro PAD_ON_UNDERFLOW_EN: pad with 0x00 after STALL_LIMIT empty cycles.
module bbframe_data_field_reader
   import bbframe_data_field_reader_pkg::*;
#(
   parameter int STALL_LIMIT = 64
) (
   input  logic        DCLK_IN,
   input  logic        RST,
   input  logic [7:0]  DATA_IN,
   input  logic [7:0]  BYTE_INDEX_A,
   input  logic        EMPTY,
   input  logic        START,
   input  logic [15:0] DFL_BYTES,
   output logic        RD_REQ,
   output logic [7:0]  DATA_OUT,
   output logic        DVALID_OUT,
   output logic [15:0] SYNCD,
   output logic        SYNCD_VALID,
   output logic        BUSY,
   output logic        FRAME_DONE
);

   if (STALL_LIMIT < 1 || STALL_LIMIT > 65535) begin : g_bad_stall_limit
      $error("STALL_LIMIT out of range");
   end

   state_t           state_r;
   logic [DFL_W-1:0] dfl_r;
   logic [DFL_W-1:0] req_cnt_r;
   logic [DFL_W-1:0] dlv_cnt_r;
   logic [15:0]      syncd_r;
   logic             syncd_found_r;
   logic             dvalid_r;
   logic             frame_done_r;
   logic             busy_r;
   logic             rd_req_s;
   logic             real_byte_s;
`ifdef PAD_ON_UNDERFLOW_EN
   localparam logic [DFL_W-1:0] STALL_LAST = DFL_W'(STALL_LIMIT - 1);
   logic             pad_r;
   logic [DFL_W-1:0] stall_cnt_r;
   assign real_byte_s = dvalid_r & ~pad_r;
`else
   assign real_byte_s = dvalid_r;
`endif

   // FIFO read request: combinational so a non-empty FIFO is read every READ cycle.
   always_comb begin
      rd_req_s = 1'b0;
      if (state_r == ST_READ && req_cnt_r < dfl_r) begin
         rd_req_s = ~EMPTY;
      end else begin
         rd_req_s = 1'b0;
      end
   end

   assign RD_REQ      = rd_req_s;
   assign DATA_OUT    = real_byte_s ? DATA_IN : 8'h00;
   assign DVALID_OUT  = dvalid_r;
   assign SYNCD       = syncd_r;
   assign SYNCD_VALID = frame_done_r;
   assign FRAME_DONE  = frame_done_r;
   assign BUSY        = busy_r;

   // Field FSM, request/delivery counters and SYNCD capture.
   always_ff @(posedge DCLK_IN or negedge RST) begin
      if (!RST) begin
         state_r       <= ST_IDLE;
         dfl_r         <= 16'd0;
         req_cnt_r     <= 16'd0;
         dlv_cnt_r     <= 16'd0;
         syncd_r       <= SYNCD_NONE;
         syncd_found_r <= 1'b0;
         dvalid_r      <= 1'b0;
         frame_done_r  <= 1'b0;
         busy_r        <= 1'b0;
`ifdef PAD_ON_UNDERFLOW_EN
         pad_r         <= 1'b0;
         stall_cnt_r   <= 16'd0;
`endif
      end else begin
         dvalid_r     <= rd_req_s;
         frame_done_r <= 1'b0;
`ifdef PAD_ON_UNDERFLOW_EN
         pad_r        <= 1'b0;
`endif
         if (dvalid_r) begin
            dlv_cnt_r <= dlv_cnt_r + 16'd1;
            if (real_byte_s && !syncd_found_r && BYTE_INDEX_A == 8'd1) begin
               syncd_r       <= syncd_bits(dlv_cnt_r);
               syncd_found_r <= 1'b1;
            end
         end
         case (state_r)
            ST_IDLE: begin
               if (START) begin
                  dfl_r         <= DFL_BYTES;
                  req_cnt_r     <= 16'd0;
                  dlv_cnt_r     <= 16'd0;
                  syncd_r       <= SYNCD_NONE;
                  syncd_found_r <= 1'b0;
                  busy_r        <= 1'b1;
`ifdef PAD_ON_UNDERFLOW_EN
                  stall_cnt_r   <= 16'd0;
`endif
                  state_r       <= (DFL_BYTES == 16'd0) ? ST_DONE : ST_READ;
               end
            end
            ST_READ: begin
               if (rd_req_s) begin
                  req_cnt_r <= req_cnt_r + 16'd1;
`ifdef PAD_ON_UNDERFLOW_EN
                  stall_cnt_r <= 16'd0;
`endif
                  if (req_cnt_r + 16'd1 == dfl_r) begin
                     state_r <= ST_DRAIN;
                  end
               end
`ifdef PAD_ON_UNDERFLOW_EN
               else if (stall_cnt_r == STALL_LAST) begin
                  stall_cnt_r <= 16'd0;
                  state_r     <= ST_PAD;
               end else begin
                  stall_cnt_r <= stall_cnt_r + 16'd1;
               end
`endif
            end
`ifdef PAD_ON_UNDERFLOW_EN
            ST_PAD: begin
               dvalid_r  <= 1'b1;
               pad_r     <= 1'b1;
               req_cnt_r <= req_cnt_r + 16'd1;
               if (req_cnt_r + 16'd1 == dfl_r) begin
                  state_r <= ST_DRAIN;
               end
            end
`endif
            ST_DRAIN: begin
               state_r <= ST_DONE;
            end
            ST_DONE: begin
               frame_done_r <= 1'b1;
               busy_r       <= 1'b0;
               state_r      <= ST_IDLE;
            end
            default: begin
               busy_r  <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bbframe_data_field_reader.sv
// Directed bench for bbframe_data_field_reader with a queue-based FIFO model.
module tb_bbframe_data_field_reader;

   logic        DCLK_IN = 1'b0;
   logic        RST;
   logic [7:0]  DATA_IN;
   logic [7:0]  BYTE_INDEX_A;
   logic        EMPTY;
   logic        START;
   logic [15:0] DFL_BYTES;
   logic        RD_REQ;
   logic [7:0]  DATA_OUT;
   logic        DVALID_OUT;
   logic [15:0] SYNCD;
   logic        SYNCD_VALID;
   logic        BUSY;
   logic        FRAME_DONE;

   int errors = 0;
   int checks = 0;

   logic [7:0] q_data[$];
   logic [7:0] q_idx[$];
   logic [7:0] exp_q[$];
   logic [7:0] out_q[$];
   int         cyc = 0;
   int         rdreq_cnt = 0;
   int         fd_cnt = 0;
   int         fd_cyc = 0;
   int         last_dv_cyc = 0;
   logic [15:0] fd_syncd = 16'h0000;
   logic        fd_svalid = 1'b0;

   bbframe_data_field_reader #(.STALL_LIMIT(64)) dut (
      .DCLK_IN(DCLK_IN), .RST(RST), .DATA_IN(DATA_IN), .BYTE_INDEX_A(BYTE_INDEX_A),
      .EMPTY(EMPTY), .START(START), .DFL_BYTES(DFL_BYTES), .RD_REQ(RD_REQ),
      .DATA_OUT(DATA_OUT), .DVALID_OUT(DVALID_OUT), .SYNCD(SYNCD),
      .SYNCD_VALID(SYNCD_VALID), .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
   );

   always #5 DCLK_IN = ~DCLK_IN;

   // FIFO model: q valid one cycle after an accepted read.
   initial begin
      logic acc;
      DATA_IN = 8'h00; BYTE_INDEX_A = 8'h00; EMPTY = 1'b1;
      forever begin
         @(negedge DCLK_IN);
         acc = RD_REQ && !EMPTY;
         @(posedge DCLK_IN);
         #1;
         if (acc && q_data.size() > 0) begin
            DATA_IN      = q_data.pop_front();
            BYTE_INDEX_A = q_idx.pop_front();
         end
         EMPTY = (q_data.size() == 0);
      end
   end

   // Output monitor sampled mid-cycle.
   initial begin
      forever begin
         @(negedge DCLK_IN);
         cyc++;
         if (RD_REQ) rdreq_cnt++;
         if (DVALID_OUT) begin
            out_q.push_back(DATA_OUT);
            last_dv_cyc = cyc;
         end
         if (FRAME_DONE) begin
            fd_cnt++;
            fd_cyc    = cyc;
            fd_syncd  = SYNCD;
            fd_svalid = SYNCD_VALID;
         end
      end
   end

   task automatic push(input logic [7:0] d, input logic [7:0] ix);
      q_data.push_back(d);
      q_idx.push_back(ix);
      exp_q.push_back(d);
   endtask

   task automatic clear_mon();
      out_q.delete();
      exp_q.delete();
      fd_cnt = 0;
      rdreq_cnt = 0;
   endtask

   task automatic start_field(input logic [15:0] d);
      @(posedge DCLK_IN); #1;
      DFL_BYTES = d; START = 1'b1;
      @(posedge DCLK_IN); #1;
      START = 1'b0;
   endtask

   task automatic wait_done(input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(posedge DCLK_IN); #1;
         if (fd_cnt > 0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      RST = 1'b0; START = 1'b0; DFL_BYTES = 16'd0;
      repeat (3) @(posedge DCLK_IN);
      #1;
      checks += 7;
      if (RD_REQ !== 1'b0)         begin errors++; $display("FAIL rst_rd_req got=%b exp=0", RD_REQ); end
      if (DVALID_OUT !== 1'b0)     begin errors++; $display("FAIL rst_dvalid got=%b exp=0", DVALID_OUT); end
      if (DATA_OUT !== 8'h00)      begin errors++; $display("FAIL rst_data got=%h exp=00", DATA_OUT); end
      if (SYNCD !== 16'hFFFF)      begin errors++; $display("FAIL rst_syncd got=%h exp=ffff", SYNCD); end
      if (SYNCD_VALID !== 1'b0)    begin errors++; $display("FAIL rst_syncd_valid got=%b exp=0", SYNCD_VALID); end
      if (BUSY !== 1'b0)           begin errors++; $display("FAIL rst_busy got=%b exp=0", BUSY); end
      if (FRAME_DONE !== 1'b0)     begin errors++; $display("FAIL rst_frame_done got=%b exp=0", FRAME_DONE); end
      RST = 1'b1;
      repeat (2) @(posedge DCLK_IN);
   endtask

   task automatic test_aligned();
      bit ok;
      clear_mon();
      for (int i = 0; i < 376; i++) push(8'(i) ^ 8'h5A, 8'((i % 188) + 1));
      start_field(16'd376);
      wait_done(2000, ok);
      checks += 5;
      if (!ok)                   begin errors++; $display("FAIL aligned_done timeout"); end
      if (out_q.size() != 376)   begin errors++; $display("FAIL aligned_count got=%0d exp=376", out_q.size()); end
      if (fd_syncd !== 16'd0)    begin errors++; $display("FAIL aligned_syncd got=%0d exp=0", fd_syncd); end
      if (fd_svalid !== 1'b1)    begin errors++; $display("FAIL aligned_syncd_valid got=%b exp=1", fd_svalid); end
      if (!(fd_cyc > last_dv_cyc)) begin errors++; $display("FAIL aligned_order done=%0d last_byte=%0d", fd_cyc, last_dv_cyc); end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL aligned_data[%0d] got=%h exp=%h", i, out_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_mid_up();
      bit ok;
      clear_mon();
      for (int i = 0; i < 200; i++) push(8'(i * 3), 8'(((99 + i) % 188) + 1));
      start_field(16'd200);
      repeat (10) @(posedge DCLK_IN);
      #1;
      DFL_BYTES = 16'd5; START = 1'b1;
      @(posedge DCLK_IN); #1;
      START = 1'b0;
      wait_done(1000, ok);
      checks += 4;
      if (!ok)                  begin errors++; $display("FAIL mid_done timeout"); end
      if (out_q.size() != 200)  begin errors++; $display("FAIL mid_count got=%0d exp=200", out_q.size()); end
      if (fd_syncd !== 16'd712) begin errors++; $display("FAIL mid_syncd got=%0d exp=712", fd_syncd); end
      if (out_q.size() > 150 && out_q[150] !== exp_q[150]) begin
         errors++; $display("FAIL mid_data150 got=%h exp=%h", out_q[150], exp_q[150]);
      end
      repeat (10) @(posedge DCLK_IN);
      #1;
      checks += 3;
      if (SYNCD !== 16'd712)    begin errors++; $display("FAIL mid_syncd_hold got=%0d exp=712", SYNCD); end
      if (fd_cnt != 1)          begin errors++; $display("FAIL mid_done_count got=%0d exp=1", fd_cnt); end
      if (BUSY !== 1'b0)        begin errors++; $display("FAIL mid_busy_after got=%b exp=0", BUSY); end
   endtask

   task automatic test_no_sync();
      bit ok;
      clear_mon();
      for (int i = 0; i < 50; i++) push(8'hC0 + 8'(i), 8'(i + 2));
      start_field(16'd50);
      wait_done(500, ok);
      checks += 4;
      if (!ok)                   begin errors++; $display("FAIL nosync_done timeout"); end
      if (out_q.size() != 50)    begin errors++; $display("FAIL nosync_count got=%0d exp=50", out_q.size()); end
      if (fd_syncd !== 16'hFFFF) begin errors++; $display("FAIL nosync_syncd got=%h exp=ffff", fd_syncd); end
      if (fd_svalid !== 1'b1)    begin errors++; $display("FAIL nosync_syncd_valid got=%b exp=1", fd_svalid); end
   endtask

   task automatic test_zero_dfl();
      clear_mon();
      @(posedge DCLK_IN); #1;
      DFL_BYTES = 16'd0; START = 1'b1;
      @(posedge DCLK_IN); #1;
      START = 1'b0;
      checks += 2;
      if (FRAME_DONE !== 1'b0) begin errors++; $display("FAIL zero_early_done got=%b exp=0", FRAME_DONE); end
      if (BUSY !== 1'b1)       begin errors++; $display("FAIL zero_busy got=%b exp=1", BUSY); end
      @(posedge DCLK_IN); #1;
      checks += 3;
      if (FRAME_DONE !== 1'b1)  begin errors++; $display("FAIL zero_done got=%b exp=1", FRAME_DONE); end
      if (SYNCD !== 16'hFFFF)   begin errors++; $display("FAIL zero_syncd got=%h exp=ffff", SYNCD); end
      @(posedge DCLK_IN); #1;
      if (rdreq_cnt != 0)       begin errors++; $display("FAIL zero_rd_req got=%0d exp=0", rdreq_cnt); end
   endtask

   task automatic test_stall();
      bit ok;
      clear_mon();
      for (int i = 0; i < 10; i++) push(8'h10 + 8'(i), 8'(i + 5));
      start_field(16'd20);
      repeat (60) @(posedge DCLK_IN);
      #1;
      checks += 2;
      if (out_q.size() != 10) begin errors++; $display("FAIL stall_early_count got=%0d exp=10", out_q.size()); end
      if (BUSY !== 1'b1)      begin errors++; $display("FAIL stall_busy got=%b exp=1", BUSY); end
`ifdef PAD_ON_UNDERFLOW_EN
      wait_done(300, ok);
      for (int i = 0; i < 10; i++) exp_q.push_back(8'h00);
`else
      repeat (100) @(posedge DCLK_IN);
      #1;
      checks += 2;
      if (out_q.size() != 10) begin errors++; $display("FAIL stall_wait_count got=%0d exp=10", out_q.size()); end
      if (fd_cnt != 0)        begin errors++; $display("FAIL stall_no_done got=%0d exp=0", fd_cnt); end
      for (int i = 0; i < 10; i++) push(8'h80 + 8'(i), 8'(i + 15));
      wait_done(300, ok);
`endif
      checks += 2;
      if (!ok)                begin errors++; $display("FAIL stall_done timeout"); end
      if (out_q.size() != 20) begin errors++; $display("FAIL stall_count got=%0d exp=20", out_q.size()); end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_data[%0d] got=%h exp=%h", i, out_q[i], exp_q[i]); end
      end
   endtask

   task automatic test_reset_mid();
      bit ok;
      bit hit;
      clear_mon();
      for (int i = 0; i < 100; i++) push(8'(i), 8'(i + 1));
      start_field(16'd100);
      hit = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge DCLK_IN); #1;
         if (out_q.size() >= 30) begin hit = 1'b1; break; end
      end
      checks++;
      if (!hit) begin errors++; $display("FAIL rstmid_reach timeout"); end
      RST = 1'b0;
      #1;
      checks += 6;
      if (RD_REQ !== 1'b0)      begin errors++; $display("FAIL rstmid_rd_req got=%b exp=0", RD_REQ); end
      if (DVALID_OUT !== 1'b0)  begin errors++; $display("FAIL rstmid_dvalid got=%b exp=0", DVALID_OUT); end
      if (DATA_OUT !== 8'h00)   begin errors++; $display("FAIL rstmid_data got=%h exp=00", DATA_OUT); end
      if (SYNCD !== 16'hFFFF)   begin errors++; $display("FAIL rstmid_syncd got=%h exp=ffff", SYNCD); end
      if (BUSY !== 1'b0)        begin errors++; $display("FAIL rstmid_busy got=%b exp=0", BUSY); end
      if (FRAME_DONE !== 1'b0)  begin errors++; $display("FAIL rstmid_done got=%b exp=0", FRAME_DONE); end
      repeat (2) @(posedge DCLK_IN);
      #1;
      RST = 1'b1;
      repeat (20) @(posedge DCLK_IN);
      #1;
      checks++;
      if (fd_cnt != 0) begin errors++; $display("FAIL rstmid_no_done got=%0d exp=0", fd_cnt); end
      q_data.delete(); q_idx.delete();
      repeat (2) @(posedge DCLK_IN);
      clear_mon();
      for (int i = 0; i < 10; i++) push(8'hA0 + 8'(i), 8'(i + 1));
      start_field(16'd10);
      wait_done(200, ok);
      checks += 3;
      if (!ok)                 begin errors++; $display("FAIL rstmid_next_done timeout"); end
      if (out_q.size() != 10)  begin errors++; $display("FAIL rstmid_next_count got=%0d exp=10", out_q.size()); end
      if (fd_syncd !== 16'd0)  begin errors++; $display("FAIL rstmid_next_syncd got=%0d exp=0", fd_syncd); end
      for (int i = 0; i < out_q.size() && i < exp_q.size(); i++) begin
         checks++;
         if (out_q[i] !== exp_q[i]) begin errors++; $display("FAIL rstmid_data[%0d] got=%h exp=%h", i, out_q[i], exp_q[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_aligned();
      test_mid_up();
      test_no_sync();
      test_zero_dfl();
      test_stall();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
